test_controller: RTL and testbench

//  Self-checking harness controller for core-level simulation: sequences core reset, snoops the

---
 rtl/test_controller.sv | 127 ++++++++++++
 tb/tb_test_controller.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/test_controller.sv
// Simulation harness controller: holds the core in reset, then snoops stores for a tohost
// verdict or a run timeout. Define TEST_CONSOLE_EN to add a character console on CONSOLE_ADDR.
module test_controller #(
    parameter int                    ADDR_WIDTH     = 32,
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    COUNT_WIDTH    = 32,
    parameter int                    RESET_CYCLES   = 3,
    parameter int                    TIMEOUT_CYCLES = 1000,
    parameter logic [ADDR_WIDTH-1:0] TOHOST_ADDR    = 32'h0000_1000,
    parameter logic [ADDR_WIDTH-1:0] CONSOLE_ADDR   = 32'h0000_1004
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    memory_write,
    input  logic [ADDR_WIDTH-1:0]   address,
    input  logic [DATA_WIDTH-1:0]   write_data,
    output logic                    core_reset,
    output logic                    done,
    output logic                    pass,
    output logic                    fail,
    output logic                    timeout,
    output logic [DATA_WIDTH-2:0]   fail_code,
    output logic [COUNT_WIDTH-1:0]  cycle_count
`ifdef TEST_CONSOLE_EN
    ,
    output logic                    console_valid,
    output logic [7:0]              console_data
`endif
);

    localparam int HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [HOLD_W-1:0]      HOLD_LAST    = HOLD_W'(RESET_CYCLES - 1);
    localparam logic [COUNT_WIDTH-1:0] TIMEOUT_LAST = COUNT_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam bit                     TIMEOUT_EN   = (TIMEOUT_CYCLES != 0);

    // A shared mailbox/console address would make every console character a verdict.
    if (RESET_CYCLES < 1 || TOHOST_ADDR == CONSOLE_ADDR) begin : g_bad_config
        $error("test_controller: RESET_CYCLES must be >=1 and TOHOST_ADDR != CONSOLE_ADDR");
    end

    typedef enum logic [2:0] {
        ST_HOLD,
        ST_RUN,
        ST_PASS,
        ST_FAIL,
        ST_TIMEOUT
    } state_t;

    state_t            state_reg;
    logic [HOLD_W-1:0] hold_cnt_reg;

    logic tohost_hit;
    logic verdict_hit;
    logic timeout_hit;

    assign tohost_hit  = memory_write && (address == TOHOST_ADDR);
    // Even tohost values are progress markers, not verdicts.
    assign verdict_hit = tohost_hit && write_data[0];
    assign timeout_hit = TIMEOUT_EN && (cycle_count == TIMEOUT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ST_HOLD;
            hold_cnt_reg <= '0;
            core_reset   <= 1'b1;
            done         <= 1'b0;
            pass         <= 1'b0;
            fail         <= 1'b0;
            timeout      <= 1'b0;
            fail_code    <= '0;
            cycle_count  <= '0;
        end else begin
            case (state_reg)
                ST_HOLD: begin
                    hold_cnt_reg <= hold_cnt_reg + 1'b1;
                    if (hold_cnt_reg == HOLD_LAST) begin
                        state_reg  <= ST_RUN;
                        core_reset <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (cycle_count != '1) begin
                        cycle_count <= cycle_count + 1'b1;
                    end
                    if (verdict_hit) begin
                        done       <= 1'b1;
                        core_reset <= 1'b1;
                        if (write_data == DATA_WIDTH'(1)) begin
                            state_reg <= ST_PASS;
                            pass      <= 1'b1;
                        end else begin
                            state_reg <= ST_FAIL;
                            fail      <= 1'b1;
                            fail_code <= write_data[DATA_WIDTH-1:1];
                        end
                    end else if (timeout_hit) begin
                        state_reg  <= ST_TIMEOUT;
                        done       <= 1'b1;
                        timeout    <= 1'b1;
                        core_reset <= 1'b1;
                    end
                end
                default: begin
                    // Terminal: everything frozen until the next reset.
                    core_reset <= 1'b1;
                end
            endcase
        end
    end

`ifdef TEST_CONSOLE_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            console_valid <= 1'b0;
            console_data  <= '0;
        end else if (state_reg == ST_RUN && memory_write && address == CONSOLE_ADDR) begin
            console_valid <= 1'b1;
            console_data  <= write_data[7:0];
        end else begin
            console_valid <= 1'b0;
        end
    end
`else
    // Without the console, CONSOLE_ADDR stores are ordinary ignored stores.
`endif

endmodule

// File: tb/tb_test_controller.sv
// Bench for test_controller: two instances (TIMEOUT_CYCLES=50 and 0) share one stimulus stream
// and are checked every cycle against a cycle-counting reference model plus literal checkpoints.
module tb_test_controller;

    localparam logic [31:0] TOHOST  = 32'h0000_1000;
    localparam logic [31:0] CONSOLE = 32'h0000_1004;
    localparam int          RC      = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        mw;
    logic [31:0] addr;
    logic [31:0] wd;

    logic [1:0]  core_reset_w, done_w, pass_w, fail_w, timeout_w;
    logic [30:0] fail_code_w [2];
    logic [31:0] cycle_count_w [2];
    logic [1:0]  cvalid_w;
    logic [7:0]  cdata_w [2];

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    test_controller #(.TIMEOUT_CYCLES(50)) dut_a (
        .clk(clk), .reset(rst), .memory_write(mw), .address(addr), .write_data(wd),
        .core_reset(core_reset_w[0]), .done(done_w[0]), .pass(pass_w[0]), .fail(fail_w[0]),
        .timeout(timeout_w[0]), .fail_code(fail_code_w[0]), .cycle_count(cycle_count_w[0])
`ifdef TEST_CONSOLE_EN
        , .console_valid(cvalid_w[0]), .console_data(cdata_w[0])
`endif
    );

    test_controller #(.TIMEOUT_CYCLES(0)) dut_b (
        .clk(clk), .reset(rst), .memory_write(mw), .address(addr), .write_data(wd),
        .core_reset(core_reset_w[1]), .done(done_w[1]), .pass(pass_w[1]), .fail(fail_w[1]),
        .timeout(timeout_w[1]), .fail_code(fail_code_w[1]), .cycle_count(cycle_count_w[1])
`ifdef TEST_CONSOLE_EN
        , .console_valid(cvalid_w[1]), .console_data(cdata_w[1])
`endif
    );

`ifndef TEST_CONSOLE_EN
    assign cvalid_w   = 2'b00;
    assign cdata_w[0] = 8'h00;
    assign cdata_w[1] = 8'h00;
`endif

    task automatic check(input string name, input longint got, input longint exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: low_edges counts clock edges since reset fell; the core runs once
    // RESET_CYCLES of them have passed and no verdict is recorded. verdict 0 none,1 pass,2 fail,3 timeout.
    int          low_edges [2];
    longint      runs      [2];
    int          verdict   [2];
    logic [30:0] code      [2];
    bit          cv        [2];
    logic [7:0]  cd        [2];

    function automatic int timeout_of(input int i);
        return (i == 0) ? 50 : 0;
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            for (int i = 0; i < 2; i++) begin
                if (rst) begin
                    low_edges[i] = 0; runs[i] = 0; verdict[i] = 0;
                    code[i] = '0; cv[i] = 0; cd[i] = 8'h00;
                end else begin
                    if (verdict[i] == 0 && low_edges[i] >= RC) begin
                        if (runs[i] < 64'hFFFF_FFFF) runs[i] = runs[i] + 1;
                        if (mw && addr == TOHOST && wd[0]) begin
                            verdict[i] = (wd == 32'd1) ? 1 : 2;
                            if (wd != 32'd1) code[i] = wd[31:1];
                        end else if (timeout_of(i) != 0 && runs[i] == timeout_of(i)) begin
                            verdict[i] = 3;
                        end
                        cv[i] = mw && (addr == CONSOLE);
                        if (cv[i]) cd[i] = wd[7:0];
                    end else begin
                        cv[i] = 0;
                    end
                    if (low_edges[i] < 1_000_000) low_edges[i]++;
                end
            end
            #1;
            for (int i = 0; i < 2; i++) begin
                check($sformatf("core_reset[%0d]", i), core_reset_w[i],
                      !(verdict[i] == 0 && low_edges[i] >= RC));
                check($sformatf("done[%0d]", i), done_w[i], verdict[i] != 0);
                check($sformatf("pass[%0d]", i), pass_w[i], verdict[i] == 1);
                check($sformatf("fail[%0d]", i), fail_w[i], verdict[i] == 2);
                check($sformatf("timeout[%0d]", i), timeout_w[i], verdict[i] == 3);
                check($sformatf("fail_code[%0d]", i), fail_code_w[i], code[i]);
                check($sformatf("cycle_count[%0d]", i), cycle_count_w[i], runs[i]);
`ifdef TEST_CONSOLE_EN
                check($sformatf("console_valid[%0d]", i), cvalid_w[i], cv[i]);
                check($sformatf("console_data[%0d]", i), cdata_w[i], cd[i]);
`endif
            end
        end
    end

    // One clock: drive at the falling edge, return just after the following rising edge.
    task automatic step(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        rst = r; mw = w; addr = a; wd = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        step(1'b0, 1'b1, a, d);
        $display("store addr=%08h data=%08h -> done=%0d pass=%0d fail=%0d timeout=%0d count=%0d",
                 a, d, done_w[0], pass_w[0], fail_w[0], timeout_w[0], cycle_count_w[0]);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 32'h0, 32'h0);
        step(1'b1, 1'b0, 32'h0, 32'h0);
    endtask

    initial begin
        rst = 1'b1; mw = 1'b0; addr = '0; wd = '0;

        // Reset release and HOLD length
        do_reset();
        check("rst core_reset", core_reset_w[0], 1);
        check("rst cycle_count", cycle_count_w[0], 0);
        idle(2);
        check("hold2 core_reset", core_reset_w[0], 1);
        idle(1);
        check("hold3 core_reset", core_reset_w[0], 0);
        check("hold3 cycle_count", cycle_count_w[0], 0);
        idle(1);
        check("run1 cycle_count", cycle_count_w[0], 1);

        // PASS, then frozen
        idle(4);
        store(TOHOST, 32'h1);
        check("pass pass", pass_w[0], 1);
        check("pass core_reset", core_reset_w[0], 1);
        check("pass cycle_count", cycle_count_w[0], 6);
        idle(3);
        check("pass frozen count", cycle_count_w[0], 6);

        // FAIL with code, later stores ignored
        do_reset();
        idle(RC + 1);
        store(TOHOST, 32'h7);
        check("fail fail", fail_w[0], 1);
        check("fail fail_code", fail_code_w[0], 3);
        store(TOHOST, 32'h1);
        check("fail sticky pass", pass_w[0], 0);
        check("fail sticky count", cycle_count_w[0], 2);

        // Ignored stores, console traffic during HOLD, then timeout
        do_reset();
        store(CONSOLE, 32'h58);
        store(TOHOST, 32'h1);
        idle(1);
        store(TOHOST, 32'h2);
        store(32'h0000_2000, 32'h1);
        check("ignored done", done_w[0], 0);
        idle(47);
        check("pre-timeout", timeout_w[0], 0);
        check("pre-timeout count", cycle_count_w[0], 49);
        idle(1);
        check("timeout timeout", timeout_w[0], 1);
        check("timeout done", done_w[0], 1);
        check("timeout count", cycle_count_w[0], 50);
        check("no-timeout inst", timeout_w[1], 0);
        store(TOHOST, 32'h1);
        check("timeout sticky", pass_w[0], 0);
        check("no-timeout inst pass", pass_w[1], 1);

        // Hit on the 50th RUN cycle beats the timeout
        do_reset();
        idle(RC + 49);
        store(TOHOST, 32'h1);
        check("race pass", pass_w[0], 1);
        check("race timeout", timeout_w[0], 0);
        check("race count", cycle_count_w[0], 50);

        // Reset pulse mid-RUN
        do_reset();
        idle(RC + 20);
        check("mid count", cycle_count_w[0], 20);
        step(1'b1, 1'b0, 32'h0, 32'h0);
        check("mid reset count", cycle_count_w[0], 0);
        check("mid reset core_reset", core_reset_w[0], 1);
        idle(2);
        check("replay core_reset", core_reset_w[0], 1);
        idle(1);
        check("replay released", core_reset_w[0], 0);

        // Console characters back-to-back
        store(CONSOLE, 32'h4F);
        store(CONSOLE, 32'h4B);
        idle(1);
`ifdef TEST_CONSOLE_EN
        check("console last char", cdata_w[0], 8'h4B);
        check("console idle valid", cvalid_w[0], 0);
`endif
        check("console not verdict", done_w[0], 0);
        idle(100);
        check("never timeout", timeout_w[1], 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
